// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU operator-entry controller and the ALU it drives.
// Stage codes double as the stage-LED encoding.
package alu_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int OP_WIDTH_DEF   = 3;

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_B  = 3'd1,
        ST_ENTER_OP = 3'd2,
        ST_EXEC     = 3'd3,
        ST_SHOW     = 3'd4
    } stage_t;

    typedef enum logic [1:0] {
        PULSE_NONE = 2'd0,
        PULSE_FWD  = 2'd1,
        PULSE_BACK = 2'd2
    } pulse_t;

    localparam logic [OP_WIDTH_DEF-1:0] OP_ADD = 3'd0;
    localparam logic [OP_WIDTH_DEF-1:0] OP_SUB = 3'd1;
    localparam logic [OP_WIDTH_DEF-1:0] OP_AND = 3'd2;
    localparam logic [OP_WIDTH_DEF-1:0] OP_OR  = 3'd3;
    localparam logic [OP_WIDTH_DEF-1:0] OP_XOR = 3'd4;
    localparam logic [OP_WIDTH_DEF-1:0] OP_NOT = 3'd5;
    localparam logic [OP_WIDTH_DEF-1:0] OP_SHL = 3'd6;
    localparam logic [OP_WIDTH_DEF-1:0] OP_SHR = 3'd7;

    // Simultaneous confirm+back is treated as no action.
    function automatic pulse_t decode_pulse(input logic confirm, input logic back);
        pulse_t p;
        case ({confirm, back})
            2'b10:   p = PULSE_FWD;
            2'b01:   p = PULSE_BACK;
            default: p = PULSE_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// Loadable saturating down-counter with terminal-count flag and synchronous clear.
// Shared by the EXEC settle wait and the SHOW idle timeout.
module alu_seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             terminal
);

    logic [WIDTH-1:0] count_r;

    // Counter register: clear beats load beats decrement; holds at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (enable && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - WIDTH'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/alu_entry_sequencer.sv
// Operator-entry FSM: collects operand A, operand B and opcode from the switches,
// starts the ALU, waits a fixed settle time, then holds the captured result for display.
module alu_entry_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int OP_WIDTH    = OP_WIDTH_DEF,
    parameter int ALU_LATENCY = 2,
    parameter int IDLE_CYCLES = 2**26
) (
    input  logic                  iClock,
    input  logic                  iReset_n,
    input  logic                  iConfirmPulse,
    input  logic                  iBackPulse,
    input  logic [DATA_WIDTH-1:0] iSwitches,
    input  logic [DATA_WIDTH-1:0] iAluResult,
    output logic [DATA_WIDTH-1:0] oOperandA,
    output logic [DATA_WIDTH-1:0] oOperandB,
    output logic [OP_WIDTH-1:0]   oOpcode,
    output logic                  oAluStart,
    output logic [DATA_WIDTH-1:0] oResult,
    output logic                  oResultValid,
    output logic [2:0]            oStage,
    output logic [DATA_WIDTH-1:0] oDisplay
);

    localparam int MAX_CNT = (ALU_LATENCY > IDLE_CYCLES) ? ALU_LATENCY : IDLE_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CNT) < 2) ? 2 : $clog2(MAX_CNT);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(ALU_LATENCY - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD   = CNT_W'(IDLE_CYCLES - 1);

    stage_t                state_r;
    stage_t                next_state_s;
    pulse_t                pulse_s;
    logic [DATA_WIDTH-1:0] operand_a_r;
    logic [DATA_WIDTH-1:0] operand_b_r;
    logic [OP_WIDTH-1:0]   opcode_r;
    logic [DATA_WIDTH-1:0] result_r;
    logic [DATA_WIDTH-1:0] display_r;
    logic [DATA_WIDTH-1:0] display_next_s;
    logic                  start_r;
    logic                  valid_r;
    logic                  cap_a_s;
    logic                  cap_b_s;
    logic                  cap_op_s;
    logic                  cap_result_s;
    logic                  timer_clear_s;
    logic                  timer_load_s;
    logic [CNT_W-1:0]      timer_value_s;
    logic                  timer_dec_s;
    logic                  timer_tc_s;

    alu_seq_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk        (iClock),
        .rst_n      (iReset_n),
        .clear      (timer_clear_s),
        .load       (timer_load_s),
        .load_value (timer_value_s),
        .enable     (timer_dec_s),
        .terminal   (timer_tc_s)
    );

    // Next-state, capture strobes and timer control.
    always_comb begin
        next_state_s  = state_r;
        pulse_s       = decode_pulse(iConfirmPulse, iBackPulse);
        cap_a_s       = 1'b0;
        cap_b_s       = 1'b0;
        cap_op_s      = 1'b0;
        cap_result_s  = 1'b0;
        timer_clear_s = 1'b0;
        timer_load_s  = 1'b0;
        timer_value_s = {CNT_W{1'b0}};
        timer_dec_s   = 1'b0;
        case (state_r)
            ST_ENTER_A: begin
                timer_clear_s = 1'b1;
                if (pulse_s == PULSE_FWD) begin
                    cap_a_s      = 1'b1;
                    next_state_s = ST_ENTER_B;
                end else begin
                    next_state_s = ST_ENTER_A;
                end
            end
            ST_ENTER_B: begin
                timer_clear_s = 1'b1;
                if (pulse_s == PULSE_FWD) begin
                    cap_b_s      = 1'b1;
                    next_state_s = ST_ENTER_OP;
                end else if (pulse_s == PULSE_BACK) begin
                    next_state_s = ST_ENTER_A;
                end else begin
                    next_state_s = ST_ENTER_B;
                end
            end
            ST_ENTER_OP: begin
                if (pulse_s == PULSE_FWD) begin
                    cap_op_s      = 1'b1;
                    timer_load_s  = 1'b1;
                    timer_value_s = SETTLE_LOAD;
                    next_state_s  = ST_EXEC;
                end else if (pulse_s == PULSE_BACK) begin
                    timer_clear_s = 1'b1;
                    next_state_s  = ST_ENTER_B;
                end else begin
                    timer_clear_s = 1'b1;
                    next_state_s  = ST_ENTER_OP;
                end
            end
            ST_EXEC: begin
                // Pulses are deliberately not looked at here.
                if (timer_tc_s) begin
                    cap_result_s  = 1'b1;
                    timer_load_s  = 1'b1;
                    timer_value_s = IDLE_LOAD;
                    next_state_s  = ST_SHOW;
                end else begin
                    timer_dec_s   = 1'b1;
                    next_state_s  = ST_EXEC;
                end
            end
            ST_SHOW: begin
                if (pulse_s == PULSE_FWD) begin
                    timer_clear_s = 1'b1;
                    next_state_s  = ST_ENTER_A;
                end else if (pulse_s == PULSE_BACK) begin
                    timer_clear_s = 1'b1;
                    next_state_s  = ST_ENTER_OP;
                end else if (iConfirmPulse || iBackPulse) begin
                    timer_load_s  = 1'b1;
                    timer_value_s = IDLE_LOAD;
                    next_state_s  = ST_SHOW;
                end else if (timer_tc_s) begin
                    timer_clear_s = 1'b1;
                    next_state_s  = ST_ENTER_A;
                end else begin
                    timer_dec_s   = 1'b1;
                    next_state_s  = ST_SHOW;
                end
            end
            default: begin
                timer_clear_s = 1'b1;
                next_state_s  = ST_ENTER_A;
            end
        endcase
    end

    // Display source follows the stage being entered so it is registered with it.
    always_comb begin
        display_next_s = {DATA_WIDTH{1'b0}};
        case (next_state_s)
            ST_ENTER_A, ST_ENTER_B, ST_ENTER_OP: display_next_s = iSwitches;
            ST_EXEC:                             display_next_s = {DATA_WIDTH{1'b0}};
            ST_SHOW: begin
                if (cap_result_s) begin
                    display_next_s = iAluResult;
                end else begin
                    display_next_s = result_r;
                end
            end
            default:                             display_next_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // State and status flag registers.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_r   <= ST_ENTER_A;
            start_r   <= 1'b0;
            valid_r   <= 1'b0;
            display_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r   <= next_state_s;
            start_r   <= (next_state_s == ST_EXEC) && (state_r != ST_EXEC);
            valid_r   <= (next_state_s == ST_SHOW);
            display_r <= display_next_s;
        end
    end

    // Operand, opcode and result capture registers.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            operand_a_r <= {DATA_WIDTH{1'b0}};
            operand_b_r <= {DATA_WIDTH{1'b0}};
            opcode_r    <= {OP_WIDTH{1'b0}};
            result_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            if (cap_a_s) begin
                operand_a_r <= iSwitches;
            end else begin
                operand_a_r <= operand_a_r;
            end
            if (cap_b_s) begin
                operand_b_r <= iSwitches;
            end else begin
                operand_b_r <= operand_b_r;
            end
            if (cap_op_s) begin
                opcode_r <= iSwitches[OP_WIDTH-1:0];
            end else begin
                opcode_r <= opcode_r;
            end
            if (cap_result_s) begin
                result_r <= iAluResult;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign oOperandA    = operand_a_r;
    assign oOperandB    = operand_b_r;
    assign oOpcode      = opcode_r;
    assign oAluStart    = start_r;
    assign oResult      = result_r;
    assign oResultValid = valid_r;
    assign oStage       = state_r;
    assign oDisplay     = display_r;

endmodule
